// File: rtl/prm_fifo_cc.sv
// prm_fifo_cc
// Single-clock synchronous FIFO with first-word-fall-through output.
// It decouples a producer from a consumer that cannot take data every cycle.
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   rst_n     - synchronous active-low reset (highest priority)
//   clr_n     - synchronous active-low flush; clears the same state as reset
//   push      - write request; d is stored when the push is accepted
//   d         - write data, WIDTH bits
//   pop       - read request; the head entry is removed when accepted
//   q         - head-of-queue data, all zeros while empty
//   empty     - FIFO holds no entries
//   full      - FIFO holds 2**DEPTH_LOG2 entries
//   count     - number of stored entries, 0..2**DEPTH_LOG2
//   overflow  - sticky flag: a push was rejected
//   underflow - sticky flag: a pop was rejected
module prm_fifo_cc #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      d,
  input  logic                  pop,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  pop_ok;
  logic                  push_ok;
  logic                  active;

  // Status is derived from the registered count only.
  assign full      = (count_r == DEPTH_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // A full FIFO can still take a push when a pop frees the head slot in the
  // same cycle; the new word then lands in the slot just vacated.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Push/pop only take effect when neither reset nor flush is asserted.
  assign active = rst_n & clr_n;

  // Zero q while empty so stale storage never leaks downstream.
  assign q = empty ? '0 : mem[rd_ptr];

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n || !clr_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (push && !push_ok) begin
        overflow_r <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (active && push_ok) begin
      mem[wr_ptr] <= d;
    end
  end

endmodule

// File: tb/tb_prm_fifo_cc.sv
// tb_prm_fifo_cc
// Self-checking bench for prm_fifo_cc (WIDTH=8, DEPTH_LOG2=2). A queue-based
// reference model predicts occupancy, head data and sticky error flags.
//
// Ports: none (top-level bench).
module tb_prm_fifo_cc;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk;
  logic                rst_n;
  logic                clr_n;
  logic                push;
  logic [WIDTH-1:0]    d;
  logic                pop;
  logic [WIDTH-1:0]    q;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                underflow;

  // Reference model state.
  logic [WIDTH-1:0] mdl[$];
  logic             mdl_ovf;
  logic             mdl_unf;

  int vectors;
  int miscompares;

  logic [WIDTH-1:0] exp_seq [4];

  prm_fifo_cc #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_n     (clr_n),
    .push      (push),
    .d         (d),
    .pop       (pop),
    .q         (q),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic applyStimulus(input logic r, input logic c, input logic p_push,
                               input logic p_pop, input logic [WIDTH-1:0] p_d);
    logic pop_ok;
    logic push_ok;
    @(negedge clk);
    rst_n = r;
    clr_n = c;
    push  = p_push;
    pop   = p_pop;
    d     = p_d;
    @(posedge clk);
    if (!r || !c) begin
      mdl.delete();
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
    end else begin
      pop_ok  = p_pop && (mdl.size() > 0);
      push_ok = p_push && ((mdl.size() < DEPTH) || pop_ok);
      if (p_pop && !pop_ok) mdl_unf = 1'b1;
      if (p_push && !push_ok) mdl_ovf = 1'b1;
      if (pop_ok) void'(mdl.pop_front());
      if (push_ok) mdl.push_back(p_d);
    end
    #1;
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] exp_q;
    exp_q = (mdl.size() == 0) ? '0 : mdl[0];
    check({tag, ".count"},     32'(count),     32'(mdl.size()));
    check({tag, ".empty"},     32'(empty),     32'(mdl.size() == 0));
    check({tag, ".full"},      32'(full),      32'(mdl.size() == DEPTH));
    check({tag, ".q"},         32'(q),         32'(exp_q));
    check({tag, ".overflow"},  32'(overflow),  32'(mdl_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(mdl_unf));
  endtask

  task automatic fillFour();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, exp_seq[i]);
      checkOutput("fill");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mdl_ovf     = 1'b0;
    mdl_unf     = 1'b0;
    rst_n       = 1'b0;
    clr_n       = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    d           = '0;
    exp_seq[0]  = 8'h11;
    exp_seq[1]  = 8'h22;
    exp_seq[2]  = 8'h33;
    exp_seq[3]  = 8'h44;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
    checkOutput("reset");
    check("reset.q_zero", 32'(q), 32'h0);
    check("reset.empty_one", 32'(empty), 32'h1);

    $display("[TB] flush with push");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h02);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h03);
    checkOutput("pre_flush");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h04);
    checkOutput("flush");
    check("flush.count_zero", 32'(count), 32'h0);

    $display("[TB] fill and drain");
    fillFour();
    check("fill.full_one", 32'(full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("drain.head", 32'(q), 32'(exp_seq[i]));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("drain");
    end
    check("drain.q_zero", 32'(q), 32'h0);

    $display("[TB] overflow");
    fillFour();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
    checkOutput("ovf");
    check("ovf.flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("ovf.head", 32'(q), 32'(exp_seq[i]));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("ovf_drain");
    end
    check("ovf.sticky", 32'(overflow), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("ovf_clear");

    $display("[TB] full push+pop");
    fillFour();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
    checkOutput("fullpp");
    check("fullpp.count", 32'(count), 32'h4);
    exp_seq[0] = 8'h22;
    exp_seq[1] = 8'h33;
    exp_seq[2] = 8'h44;
    exp_seq[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      check("fullpp.head", 32'(q), 32'(exp_seq[i]));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("fullpp_drain");
    end

    $display("[TB] empty push+pop");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
    checkOutput("emptypp");
    check("emptypp.q", 32'(q), 32'hAA);
    check("emptypp.unf", 32'(underflow), 32'h1);

    $display("[TB] random wrap stress");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rand_start");
    for (int i = 0; i < 1000; i++) begin
      logic c;
      c = ($urandom_range(0, 63) != 0);
      applyStimulus(1'b1, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    WIDTH'($urandom));
      checkOutput("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prm_fifo_cc.md
Name: prm_fifo_cc

Overview:
Single-clock synchronous FIFO that buffers a data stream and feeds a downstream prm-style register stage. It has first-word-fall-through output, a synchronous flush input (clr_n) with the same semantics as the register stages, full/empty/count status, and sticky overflow/underflow error flags. It decouples a producer from a consumer that cannot accept data every cycle.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH_LOG2, 2, log2 of the number of entries; depth = 2**DEPTH_LOG2 (>=1)

Ports:
clk  input  1  clock; all state changes on its rising edge
rst_n  input  1  reset; synchronous, active-low
clr_n  input  1  synchronous flush, active-low
push  input  1  write request; d is written when accepted
d  input  WIDTH  write data
pop  input  1  read request; the head entry is removed when accepted
q  output  WIDTH  head-of-queue data, valid while empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
count  output  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2
overflow  output  1  sticky: a push was rejected
underflow  output  1  sticky: a pop was rejected

Behaviour:
- Storage: 2**DEPTH_LOG2 x WIDTH array. Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth. count is a separate register; full = (count == depth), empty = (count == 0).
- Reset: when rst_n = 0 at a clk edge, pointers, count, overflow and underflow go to 0. This gives empty=1, full=0, count=0. Storage contents are not reset. rst_n has priority over everything else.
- Flush: when clr_n = 0 (and rst_n = 1) at a clk edge, the same state is cleared as on reset. The flush has priority over push and pop, so push/pop in that cycle are ignored and raise no error flags.
- q = storage[rd_ptr] when empty = 0, and is driven to all-zeros when empty = 1. Latency: a word pushed into an empty FIFO appears on q, with empty = 0, in the cycle after the push edge.
- Push acceptance: push=1 is accepted when full=0, or when full=1 and pop=1 is accepted in the same cycle. On acceptance, d is written to storage[wr_ptr] and wr_ptr increments (with wrap).
- Push rejection: a push that is not accepted leaves storage unchanged and sets overflow to 1.
- Pop acceptance: pop=1 is accepted when empty=0, and rd_ptr increments (with wrap).
- Pop rejection: pop=1 with empty=1 is rejected and sets underflow to 1. This applies even if push=1 in the same cycle; in that case the push is still accepted. There is no bypass of data from d to q.
- count update: +1 for an accepted push only, -1 for an accepted pop only, unchanged when both or neither are accepted. count never leaves the range 0..depth.
- Simultaneous push+pop when full: both are accepted, count stays at depth, and the new word lands in the slot just freed.
- Error flags: overflow and underflow stay at 1 until reset or flush. Setting them does not otherwise change FIFO state.
- Wrap-around: after any number of operations, data order is strictly first-in first-out.
- Outputs are functions of registered state only. The one exception is that q reads the array at rd_ptr.

Test Plan:
- Reset/flush: hold rst_n=0 for 2 cycles -> empty=1, full=0, count=0, q=0, overflow=0, underflow=0. Then push 3 words, pulse clr_n=0 together with push=1 -> count=0, empty=1, overflow=0.
- Fill/drain (WIDTH=8, DEPTH_LOG2=2): push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> full=1 and count=4 after the 4th edge. Pop 4 times -> q reads 11, 22, 33, 44 in order, then empty=1 and q=0.
- Overflow: with the FIFO full, push 8'h55 with pop=0 -> overflow=1, count=4, and the next 4 pops return 11..44 (55 is absent). overflow stays at 1 until clr_n=0.
- Full push+pop: fill with 11..44, then assert push=1 with d=8'h55 and pop=1 for one cycle -> count=4, overflow=0. Subsequent pops return 22, 33, 44, 55.
- Underflow and empty push+pop: from empty, assert pop=1 with push=1 and d=8'hAA -> underflow=1, count=1, q=8'hAA next cycle.
- Wrap stress: random push/pop for 1000 cycles against a scoreboard queue model -> every popped q matches the model, count matches the model size, and no error flags are set unless the model predicts a reject.
